// File: rtl/char_blit_pkg.sv
// char_blit_pkg: shared constants and types for the character blitter.
//   - Character codes: CHAR_A..CHAR_Z = 0..25, CHAR_0..CHAR_9 = 26..35,
//     CHAR_SPACE = 36. Codes 37..63 render as blank cells.
//   - Datapath widths: CODE_W, COORD_W and COLOUR_W.
//   - state_t: blitter FSM states.
package char_blit_pkg;

  localparam int CODE_W   = 6;
  localparam int COORD_W  = 8;
  localparam int COLOUR_W = 6;

  localparam logic [CODE_W-1:0] CHAR_A = 6'd0,  CHAR_B = 6'd1,  CHAR_C = 6'd2,  CHAR_D = 6'd3;
  localparam logic [CODE_W-1:0] CHAR_E = 6'd4,  CHAR_F = 6'd5,  CHAR_G = 6'd6,  CHAR_H = 6'd7;
  localparam logic [CODE_W-1:0] CHAR_I = 6'd8,  CHAR_J = 6'd9,  CHAR_K = 6'd10, CHAR_L = 6'd11;
  localparam logic [CODE_W-1:0] CHAR_M = 6'd12, CHAR_N = 6'd13, CHAR_O = 6'd14, CHAR_P = 6'd15;
  localparam logic [CODE_W-1:0] CHAR_Q = 6'd16, CHAR_R = 6'd17, CHAR_S = 6'd18, CHAR_T = 6'd19;
  localparam logic [CODE_W-1:0] CHAR_U = 6'd20, CHAR_V = 6'd21, CHAR_W = 6'd22, CHAR_X = 6'd23;
  localparam logic [CODE_W-1:0] CHAR_Y = 6'd24, CHAR_Z = 6'd25;
  localparam logic [CODE_W-1:0] CHAR_0 = 6'd26, CHAR_1 = 6'd27, CHAR_2 = 6'd28, CHAR_3 = 6'd29;
  localparam logic [CODE_W-1:0] CHAR_4 = 6'd30, CHAR_5 = 6'd31, CHAR_6 = 6'd32, CHAR_7 = 6'd33;
  localparam logic [CODE_W-1:0] CHAR_8 = 6'd34, CHAR_9 = 6'd35, CHAR_SPACE = 6'd36;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational font lookup.
//   char_code : glyph index (see char_blit_pkg)
//   row       : glyph row, 0 = top
//   row_word  : GLYPH_W pixel bits for that row, MSB = leftmost column
// The font is drawn on an 8x10 grid; columns beyond 8 and rows beyond 10
// read as blank, and unknown codes return an all-zero cell.
module glyph_rom
  import char_blit_pkg::*;
#(
  parameter int GLYPH_W = 8,
  parameter int ROW_W   = 4
) (
  input  logic [CODE_W-1:0]  char_code,
  input  logic [ROW_W-1:0]   row,
  output logic [GLYPH_W-1:0] row_word
);

  // Ten bytes per glyph, row 0 in the most significant byte.
  logic [79:0] glyph;
  logic [79:0] shifted;
  logic [7:0]  row_byte;

  always_comb begin
    case (char_code)
      CHAR_A:     glyph = 80'h0C_12_21_21_21_3F_21_21_21_21;
      CHAR_B:     glyph = 80'h3E_21_21_21_21_3E_21_21_21_3E;
      CHAR_C:     glyph = 80'h1E_21_20_20_20_20_20_20_21_1E;
      CHAR_D:     glyph = 80'h3E_21_21_21_21_21_21_21_21_3E;
      CHAR_E:     glyph = 80'h3F_20_20_20_3E_20_20_20_20_3F;
      CHAR_F:     glyph = 80'h3F_20_20_20_3E_20_20_20_20_20;
      CHAR_G:     glyph = 80'h1E_21_20_20_27_21_21_21_21_1E;
      CHAR_H:     glyph = 80'h21_21_21_21_3F_21_21_21_21_21;
      CHAR_I:     glyph = 80'h1E_0C_0C_0C_0C_0C_0C_0C_0C_1E;
      CHAR_J:     glyph = 80'h0F_02_02_02_02_02_02_22_22_1C;
      CHAR_K:     glyph = 80'h21_22_24_28_30_30_28_24_22_21;
      CHAR_L:     glyph = 80'h20_20_20_20_20_20_20_20_20_3F;
      CHAR_M:     glyph = 80'h21_33_2D_21_21_21_21_21_21_21;
      CHAR_N:     glyph = 80'h21_31_29_25_23_21_21_21_21_21;
      CHAR_O:     glyph = 80'h1E_21_21_21_21_21_21_21_21_1E;
      CHAR_P:     glyph = 80'h3E_21_21_21_3E_20_20_20_20_20;
      CHAR_Q:     glyph = 80'h1E_21_21_21_21_21_25_23_21_1F;
      CHAR_R:     glyph = 80'h3E_21_21_21_3E_28_24_22_21_21;
      CHAR_S:     glyph = 80'h1E_21_20_20_1E_01_01_01_21_1E;
      CHAR_T:     glyph = 80'h3F_0C_0C_0C_0C_0C_0C_0C_0C_0C;
      CHAR_U:     glyph = 80'h21_21_21_21_21_21_21_21_21_1E;
      CHAR_V:     glyph = 80'h21_21_21_21_21_21_12_12_0C_0C;
      CHAR_W:     glyph = 80'h21_21_21_21_21_21_2D_2D_33_21;
      CHAR_X:     glyph = 80'h21_21_12_12_0C_0C_12_12_21_21;
      CHAR_Y:     glyph = 80'h21_21_12_12_0C_0C_0C_0C_0C_0C;
      CHAR_Z:     glyph = 80'h3F_01_02_02_04_08_10_10_20_3F;
      CHAR_0:     glyph = 80'h1E_21_23_25_25_29_29_31_21_1E;
      CHAR_1:     glyph = 80'h0C_1C_0C_0C_0C_0C_0C_0C_0C_1E;
      CHAR_2:     glyph = 80'h1E_21_01_01_02_04_08_10_20_3F;
      CHAR_3:     glyph = 80'h1E_21_01_01_0E_01_01_01_21_1E;
      CHAR_4:     glyph = 80'h02_06_0A_12_22_3F_02_02_02_02;
      CHAR_5:     glyph = 80'h3F_20_20_3E_01_01_01_01_21_1E;
      CHAR_6:     glyph = 80'h1E_20_20_3E_21_21_21_21_21_1E;
      CHAR_7:     glyph = 80'h3F_01_02_02_04_04_08_08_08_08;
      CHAR_8:     glyph = 80'h1E_21_21_21_1E_21_21_21_21_1E;
      CHAR_9:     glyph = 80'h1E_21_21_21_1F_01_01_01_01_1E;
      CHAR_SPACE: glyph = '0;
      default:    glyph = '0;
    endcase
  end

  always_comb begin
    shifted  = glyph << (8 * 32'(row));
    row_byte = (32'(row) < 32'd10) ? shifted[79:72] : '0;
  end

  for (genvar c = 0; c < GLYPH_W; c++) begin : g_col
    if (c < 8) begin : g_font
      assign row_word[GLYPH_W-1-c] = row_byte[7-c];
    end else begin : g_pad
      assign row_word[GLYPH_W-1-c] = 1'b0;
    end
  end

endmodule

// File: rtl/char_blitter.sv
// char_blitter: sequential glyph renderer feeding the framebuffer plot path.
//   clock, resetn        : clock, asynchronous active-low reset
//   start                : render request, sampled only while idle
//   char_code            : glyph index (char_blit_pkg codes)
//   origin_x, origin_y   : top-left screen coordinate of the cell
//   colour, bg_colour    : foreground / background colour
//   plot, plot_ready     : plot request valid/ready handshake
//   plot_x, plot_y       : pixel coordinate (wraps modulo 256)
//   plot_colour          : pixel colour
//   busy                 : high from start acceptance until done
//   done                 : one-cycle pulse after the cell completes
// Build option CHAR_BLIT_BG_EN: when defined the cell is opaque and unset
// pixels are plotted in bg_colour; otherwise only set pixels are plotted.
module char_blitter
  import char_blit_pkg::*;
#(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 10,
  parameter int SCALE   = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [CODE_W-1:0]   char_code,
  input  logic [COORD_W-1:0]  origin_x,
  input  logic [COORD_W-1:0]  origin_y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic                plot,
  input  logic                plot_ready,
  output logic [COORD_W-1:0]  plot_x,
  output logic [COORD_W-1:0]  plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                busy,
  output logic                done
);

  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  state_t state, next_state;

  logic [CODE_W-1:0]   code_q;
  logic [COORD_W-1:0]  ox_q, oy_q;
  logic [COLOUR_W-1:0] fg_q;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic [SUB_W-1:0]    sx, sy;
  logic                exhausted;

  // One-entry stage between pixel evaluation and the output register; the
  // whole pipe (counters, stage, output) freezes together on a stall, so no
  // pixel can be lost or duplicated.
  logic                stage_vld;
  logic [COORD_W-1:0]  stage_x, stage_y;
  logic [COLOUR_W-1:0] stage_c;

  logic [GLYPH_W-1:0]  row_word, word_sh;
  logic                pix_bit, emit, advance, drained;
  logic                sx_last, col_last, sy_last, row_last;
  logic [COORD_W-1:0]  pix_x, pix_y;
  logic [COLOUR_W-1:0] pix_c;

`ifdef CHAR_BLIT_BG_EN
  logic [COLOUR_W-1:0] bg_q;
`else
  logic unused_bg;
  assign unused_bg = ^bg_colour;
`endif

  glyph_rom #(.GLYPH_W(GLYPH_W), .ROW_W(ROW_W)) u_rom (
    .char_code (code_q),
    .row       (row),
    .row_word  (row_word)
  );

  always_comb begin
    sx_last  = (sx  == SUB_W'(SCALE - 1));
    col_last = (col == COL_W'(GLYPH_W - 1));
    sy_last  = (sy  == SUB_W'(SCALE - 1));
    row_last = (row == ROW_W'(GLYPH_H - 1));
    word_sh  = row_word << col;
    pix_bit  = word_sh[GLYPH_W-1];
`ifdef CHAR_BLIT_BG_EN
    emit     = 1'b1;
    pix_c    = pix_bit ? fg_q : bg_q;
`else
    emit     = pix_bit;
    pix_c    = fg_q;
`endif
    pix_x    = ox_q + COORD_W'(col) * COORD_W'(SCALE) + COORD_W'(sx);
    pix_y    = oy_q + COORD_W'(row) * COORD_W'(SCALE) + COORD_W'(sy);
    advance  = !(plot && !plot_ready);
    // Every pixel evaluated, stage empty and the output either empty or
    // being accepted on this edge.
    drained  = exhausted && !stage_vld && advance;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (drained) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      code_q      <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      fg_q        <= '0;
`ifdef CHAR_BLIT_BG_EN
      bg_q        <= '0;
`endif
      row         <= '0;
      col         <= '0;
      sx          <= '0;
      sy          <= '0;
      exhausted   <= 1'b0;
      stage_vld   <= 1'b0;
      stage_x     <= '0;
      stage_y     <= '0;
      stage_c     <= '0;
      plot        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        code_q    <= char_code;
        ox_q      <= origin_x;
        oy_q      <= origin_y;
        fg_q      <= colour;
`ifdef CHAR_BLIT_BG_EN
        bg_q      <= bg_colour;
`endif
        row       <= '0;
        col       <= '0;
        sx        <= '0;
        sy        <= '0;
        exhausted <= 1'b0;
        stage_vld <= 1'b0;
      end
    end else if (state == SCAN && advance) begin
      plot <= stage_vld;
      if (stage_vld) begin
        plot_x      <= stage_x;
        plot_y      <= stage_y;
        plot_colour <= stage_c;
      end
      if (!exhausted) begin
        stage_vld <= emit;
        stage_x   <= pix_x;
        stage_y   <= pix_y;
        stage_c   <= pix_c;
        if (!sx_last) begin
          sx <= sx + 1'b1;
        end else begin
          sx <= '0;
          if (!col_last) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            if (!sy_last) begin
              sy <= sy + 1'b1;
            end else begin
              sy <= '0;
              if (!row_last) row <= row + 1'b1;
              else           exhausted <= 1'b1;
            end
          end
        end
      end else begin
        stage_vld <= 1'b0;
      end
    end
  end

endmodule
